// File: rtl/flash_sequencer_if.sv
// Bundles the flash sequencer's strobes and frame-aligned attribute outputs.
// The master side drives tick, frame and mode strobes; the slave side owns the visible attributes.
interface flash_sequencer_if #(
  parameter int COLOR_W = 3
);
  logic               tick;
  logic               frame_start;
  logic [1:0]         mode;
  logic               mode_we;
  logic               flash_on;
  logic [COLOR_W-1:0] color_idx;
  logic               overrun;

  modport master (
    output tick, frame_start, mode, mode_we,
    input  flash_on, color_idx, overrun
  );

  modport slave (
    input  tick, frame_start, mode, mode_we,
    output flash_on, color_idx, overrun
  );
endinterface

// File: rtl/flash_sequencer.sv
// Turns the flash-rate tick into blink / colour-cycle attributes held in a shadow copy,
// and publishes them only at frame_start so a change never tears mid-frame.
module flash_sequencer #(
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 2,
  parameter int NCOLORS   = 8,
  parameter int COLOR_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  flash_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOLID,
    S_ON,
    S_OFFPH,
    S_CYC
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SOLID = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_CYCLE = 2'd3;

  localparam logic [3:0]         ON_LAST    = 4'(ON_TICKS - 1);
  localparam logic [3:0]         OFF_LAST   = 4'(OFF_TICKS - 1);
  localparam logic [COLOR_W-1:0] COLOR_LAST = COLOR_W'(NCOLORS - 1);

  logic [1:0]         mode_q, mode_d;
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               shadow_on_q, shadow_on_d;
  logic [COLOR_W-1:0] shadow_color_q, shadow_color_d;
  logic [1:0]         tick_cnt_q, tick_cnt_d;
  logic               flash_on_q, flash_on_d;
  logic [COLOR_W-1:0] color_idx_q, color_idx_d;
  logic               overrun_q, overrun_d;

  // Phase machine: a mode load takes priority over a coincident tick.
  always_comb begin
    mode_d         = mode_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_color_d = shadow_color_q;

    if (bus.mode_we) begin
      mode_d = bus.mode;
      cnt_d  = 4'd0;
      unique case (bus.mode)
        MODE_OFF:   state_d = S_IDLE;
        MODE_SOLID: state_d = S_SOLID;
        MODE_BLINK: state_d = S_ON;
        MODE_CYCLE: state_d = S_CYC;
        default:    state_d = S_IDLE;
      endcase
    end else if (bus.tick) begin
      if (mode_q == MODE_BLINK) begin
        unique case (state_q)
          S_ON: begin
            if (cnt_q == ON_LAST) begin
              cnt_d   = 4'd0;
              state_d = S_OFFPH;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_OFFPH: begin
            if (cnt_q == OFF_LAST) begin
              cnt_d   = 4'd0;
              state_d = S_ON;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end else if (mode_q == MODE_CYCLE && state_q == S_CYC) begin
        // The >= keeps the index in range even if the register were ever corrupted.
        if (shadow_color_q >= COLOR_LAST) begin
          shadow_color_d = '0;
        end else begin
          shadow_color_d = shadow_color_q + COLOR_W'(1);
        end
      end
    end

    shadow_on_d = (state_d == S_SOLID) || (state_d == S_ON) || (state_d == S_CYC);
  end

  // Frame-aligned publishing and per-window tick accounting.
  always_comb begin
    flash_on_d  = flash_on_q;
    color_idx_d = color_idx_q;
    overrun_d   = 1'b0;
    tick_cnt_d  = tick_cnt_q;

    if (bus.frame_start) begin
      flash_on_d  = shadow_on_q;
      color_idx_d = shadow_color_q;
      overrun_d   = (tick_cnt_q >= 2'd2);
      // A tick on the frame edge belongs to the window that is just opening.
      tick_cnt_d  = bus.tick ? 2'd1 : 2'd0;
    end else if (bus.tick && tick_cnt_q != 2'd3) begin
      tick_cnt_d = tick_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q         <= MODE_OFF;
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      shadow_on_q    <= 1'b0;
      shadow_color_q <= '0;
      tick_cnt_q     <= 2'd0;
      flash_on_q     <= 1'b0;
      color_idx_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_on_q    <= shadow_on_d;
      shadow_color_q <= shadow_color_d;
      tick_cnt_q     <= tick_cnt_d;
      flash_on_q     <= flash_on_d;
      color_idx_q    <= color_idx_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.flash_on  = flash_on_q;
  assign bus.color_idx = color_idx_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// Self-checking bench: a position/modulo model of the blink and colour behaviour is compared
// against the DUT every cycle, with directed scenarios pinned to hand-computed sequences.
module tb_flash_sequencer;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int NCOLORS   = 8;
  localparam int COLOR_W   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  flash_sequencer_if #(.COLOR_W(COLOR_W)) bus ();

  flash_sequencer #(
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .NCOLORS  (NCOLORS),
    .COLOR_W  (COLOR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: blink is a position on a circle of ON+OFF ticks, colour is a counter mod NCOLORS.
  int m_mode  = 0;
  int m_pos   = 0;
  int m_color = 0;
  int m_ticks = 0;
  int e_flash = 0;
  int e_color = 0;
  int e_ovr   = 0;

  function automatic int shadow_on_of(input int md, input int pos);
    case (md)
      1:       return 1;
      2:       return (pos < ON_TICKS) ? 1 : 0;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_pos = 0; m_color = 0; m_ticks = 0;
      e_flash = 0; e_color = 0; e_ovr = 0;
    end else begin
      e_ovr = 0;
      if (bus.frame_start) begin
        e_flash = shadow_on_of(m_mode, m_pos);
        e_color = m_color;
        e_ovr   = (m_ticks >= 2) ? 1 : 0;
        m_ticks = bus.tick ? 1 : 0;
      end else if (bus.tick) begin
        m_ticks++;
      end
      if (bus.mode_we) begin
        m_mode = int'(bus.mode);
        m_pos  = 0;
      end else if (bus.tick) begin
        if (m_mode == 2) m_pos = (m_pos + 1) % (ON_TICKS + OFF_TICKS);
        else if (m_mode == 3) m_color = (m_color + 1) % NCOLORS;
      end
    end
  end

  always @(negedge clk) begin
    check("flash_on", 32'(bus.flash_on), 32'(e_flash));
    check("color_idx", 32'(bus.color_idx), 32'(e_color));
    check("overrun", 32'(bus.overrun), 32'(e_ovr));
  end

  // Holds the given inputs across exactly one rising edge, returning 1 time unit after it.
  task automatic step(input logic t, input logic f, input logic we, input logic [1:0] m);
    bus.tick        = t;
    bus.frame_start = f;
    bus.mode_we     = we;
    bus.mode        = m;
    @(posedge clk);
    #1;
    bus.tick        = 1'b0;
    bus.frame_start = 1'b0;
    bus.mode_we     = 1'b0;
    bus.mode        = 2'd0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  int blink_exp [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int color_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

  initial begin
    bus.tick = 1'b0; bus.frame_start = 1'b0; bus.mode_we = 1'b0; bus.mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flash_on", 32'(bus.flash_on), 32'd0);
    check("reset_color_idx", 32'(bus.color_idx), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0;

    // OFF mode, no ticks, frames every 100 clocks.
    for (int i = 0; i < 3; i++) begin
      idle(99);
      step(1'b0, 1'b1, 1'b0, 2'd0);
      check("off_flash_on", 32'(bus.flash_on), 32'd0);
    end

    // BLINK with one tick per frame window.
    step(1'b0, 1'b0, 1'b1, 2'd2);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0);
      check("blink_seq", 32'(bus.flash_on), 32'(blink_exp[i]));
      step(1'b1, 1'b0, 1'b0, 2'd0);
      idle(2);
    end

    // Tick + SOLID load + frame together while in the OFF phase.
    step(1'b0, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < ON_TICKS; i++) step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("offph_setup", 32'(bus.flash_on), 32'd0);
    step(1'b1, 1'b1, 1'b1, 2'd1);
    check("coincide_frame", 32'(bus.flash_on), 32'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("coincide_next", 32'(bus.flash_on), 32'd1);

    // CYCLE with one tick per window: wraps past NCOLORS-1.
    step(1'b0, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0);
      idle(1);
      step(1'b0, 1'b1, 1'b0, 2'd0);
      check("cycle_seq", 32'(bus.color_idx), 32'(color_exp[i]));
    end

    // Three ticks in one window: colour jumps by 3 and overrun pulses once.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0);
      idle(1);
    end
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("overrun_color", 32'(bus.color_idx), 32'd5);
    check("overrun_pulse", 32'(bus.overrun), 32'd1);
    idle(1);
    check("overrun_clear", 32'(bus.overrun), 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("single_tick_ovr", 32'(bus.overrun), 32'd0);
    check("single_tick_col", 32'(bus.color_idx), 32'd6);

    // A tick coinciding with a mode load must not advance the colour.
    step(1'b1, 1'b0, 1'b1, 2'd3);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("tick_ignored", 32'(bus.color_idx), 32'd6);

    // Asynchronous reset mid-BLINK while visible attributes are non-zero.
    step(1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("pre_reset_on", 32'(bus.flash_on), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_flash_on", 32'(bus.flash_on), 32'd0);
    check("async_color_idx", 32'(bus.color_idx), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 1'b0, 2'd0);
      check("post_reset_on", 32'(bus.flash_on), 32'd0);
      check("post_reset_col", 32'(bus.color_idx), 32'd0);
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_sequencer.md
Name: flash_sequencer

Overview:
- Consumes the slow flash-rate enable pulse (`tick`, one clk wide) from the flash clock divider.
- Turns it into frame-aligned blink and colour-cycle attributes for the VGA pixel generator.
- Runs a mode-selectable phase state machine on a shadow copy of the attributes.
- Visible outputs update only on `frame_start`, so a change never lands mid-frame (no tearing).

Parameters:
- ON_TICKS, 3, ticks spent in the ON phase in BLINK mode (legal range 1..15).
- OFF_TICKS, 2, ticks spent in the OFF phase in BLINK mode (legal range 1..15).
- NCOLORS, 8, number of palette entries cycled in CYCLE mode (legal range 2..2^COLOR_W).
- COLOR_W, 3, width of the colour index.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  flash-rate enable, one-cycle pulse from the flash clock divider.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- mode  in  2  requested mode: 0 OFF, 1 SOLID, 2 BLINK, 3 CYCLE.
- mode_we  in  1  load `mode`, one-cycle strobe.
- flash_on  out  1  frame-aligned visibility of the flashing element.
- color_idx  out  COLOR_W  frame-aligned palette index.
- overrun  out  1  one-cycle pulse; more than one tick occurred since the previous frame_start.

Behaviour:
- Interface: one clock, `clk`. `reset` is asynchronous, active-high.
- Reset state (all registers): mode_r=0 (OFF); phase state=S_IDLE; phase count=0; shadow_on=0; shadow_color=0; tick count=0; flash_on=0; color_idx=0; overrun=0.
- Mode load: on `mode_we`, mode_r <= mode next cycle.
  - The phase machine restarts in the same edge; rewriting the current mode also restarts it.
  - If `mode_we` and `tick` occur in the same cycle, mode_we wins and that tick is ignored by the phase machine. It is still counted for overrun.
- Phase state machine (updates shadow registers only):
  - S_IDLE: used for OFF. shadow_on=0.
  - S_SOLID: shadow_on=1. Ticks are ignored.
  - S_ON: shadow_on=1. On each tick, count+1. When the count reaches ON_TICKS-1 on a tick: count <= 0, go to S_OFFPH.
  - S_OFFPH: shadow_on=0. Same rule using OFF_TICKS, then go to S_ON.
  - S_CYC: shadow_on=1. On each tick, shadow_color <= (shadow_color == NCOLORS-1) ? 0 : shadow_color+1. Wrap-around is mandatory and no out-of-range value is ever produced.
  - Mode-load entry states: OFF→S_IDLE, SOLID→S_SOLID, BLINK→S_ON with count=0, CYCLE→S_CYC.
  - shadow_color is preserved across mode changes; only reset clears it.
- Frame alignment: on frame_start, flash_on <= shadow_on and color_idx <= shadow_color, visible one cycle later.
  - If frame_start coincides with tick or mode_we, the outputs copy the pre-edge shadow values. The tick/mode effect becomes visible at the next frame_start.
  - Without frame_start, the outputs hold indefinitely while the shadow keeps advancing.
- Overrun detection: a 2-bit saturating counter counts ticks since the last frame_start.
  - On frame_start, overrun pulses high for 1 cycle if count ≥ 2, then the count is cleared.
  - A tick in the same cycle as frame_start counts toward the next frame window.
- Latency: tick → shadow: 1 cycle. Shadow → output: next frame_start edge.
- Reset mid-operation: asynchronous return to the reset state. The first frame_start after release outputs flash_on=0, color_idx=0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then frame_start every 100 clk with no ticks → flash_on=0, color_idx=0, overrun=0 throughout.
- mode_we with mode=2 (defaults); one tick between consecutive frame_starts → flash_on per frame: 1,1,1,0,0,1,1,1,0,0…
- mode_we with mode=3, tick/frame alternating for 10 ticks → color_idx sequence 1,2,…,7,0,1,2 (wrap at NCOLORS-1).
- Apply 3 ticks inside one frame window in CYCLE mode → next frame_start: color_idx advances by 3, overrun=1 for exactly one cycle. Next window with 1 tick → overrun=0.
- tick, mode_we (mode=1) and frame_start asserted in the same cycle while in S_OFFPH:
  - That frame shows flash_on=0.
  - The following frame shows flash_on=1.
  - The tick does not advance the phase count.
- Assert reset mid-BLINK with flash_on=1 → flash_on and color_idx = 0 asynchronously. After release in OFF mode, they remain 0 across frame_starts.
